// File: rtl/fas_pkg.sv
// Shared types and constants for the FAS peak-analysis datapath.
package fas_pkg;

  localparam int NPTS    = 16;
  localparam int DW      = 16;
  localparam int FRAME_W = NPTS * 2 * DW;
  localparam int POW_W   = 2 * DW + 1;
  localparam int IDX_W   = $clog2(NPTS);

  // One FFT point: real part in the upper half, imaginary in the lower half.
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  // Extract point i from a packed frame (point n sits at [32n+31:32n]).
  function automatic cplx_t get_point(input logic [FRAME_W-1:0] frame,
                                      input logic [IDX_W-1:0]   i);
    return frame[int'(i) * 2 * DW +: 2 * DW];
  endfunction

endpackage

// File: rtl/fas_peak_analyzer_if.sv
// Frame input and result output bundle between the FFT stage and the analyzer.
interface fas_peak_analyzer_if;
  import fas_pkg::*;

  logic               fft_valid;
  logic [FRAME_W-1:0] fft_frame;
  logic               done;
  logic [IDX_W-1:0]   freq;
  logic               busy;
  logic               frame_drop;

  modport master (
    output fft_valid, fft_frame,
    input  done, freq, busy, frame_drop
  );

  modport slave (
    input  fft_valid, fft_frame,
    output done, freq, busy, frame_drop
  );

endinterface

// File: rtl/fas_cplx_power.sv
// Combinational power of one complex point: re^2 + im^2, unsigned, never overflows.
module fas_cplx_power
  import fas_pkg::*;
(
  input  cplx_t             pt,
  output logic [POW_W-1:0]  pow
);

  logic signed [2*DW-1:0] re_ext, im_ext, re_sq, im_sq;

  // Sign-extend before squaring so the full 32-bit product is kept.
  always_comb begin
    re_ext = (2*DW)'(pt.re);
    im_ext = (2*DW)'(pt.im);
    re_sq  = re_ext * re_ext;
    im_sq  = im_ext * im_ext;
    pow    = {1'b0, re_sq} + {1'b0, im_sq};
  end

endmodule

// File: rtl/fas_peak_analyzer.sv
// Finds the peak-power bin of each 16-point FFT frame, with a one-deep pending buffer.
module fas_peak_analyzer
  import fas_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fas_peak_analyzer_if.slave bus
);

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_a, frame_p;
  logic               pv;
  logic [IDX_W-1:0]   idx, max_idx, freq_q;
  logic [POW_W-1:0]   max_pow, pow;
  logic               done_q, drop_q;

  logic               load_a, move_p, store_p, clear_pv, start, drop;
  logic               last, better;
  cplx_t              pt;

  // Select the current point and compute its power.
  always_comb begin
    pt     = get_point(frame_a, idx);
    last   = (state_q == SCAN) && (idx == IDX_W'(NPTS - 1));
    better = (pow > max_pow);
  end

  fas_cplx_power u_pow (
    .pt  (pt),
    .pow (pow)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and buffer-control decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would infer a latch.
    state_d  = state_q;
    load_a   = 1'b0;
    move_p   = 1'b0;
    store_p  = 1'b0;
    clear_pv = 1'b0;
    start    = 1'b0;
    drop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.fft_valid) begin
          load_a  = 1'b1;
          start   = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (last) begin
          // The active slot frees on this edge; a pending frame takes it first.
          if (pv) begin
            move_p = 1'b1;
            start  = 1'b1;
            if (bus.fft_valid) store_p  = 1'b1;
            else               clear_pv = 1'b1;
          end else if (bus.fft_valid) begin
            load_a = 1'b1;
            start  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.fft_valid) begin
          if (pv) drop    = 1'b1;
          else    store_p = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame storage.
  always_ff @(posedge clk) begin
    // NOTE: the 512-bit frame buffers carry no reset; their contents are only
    // used when the FSM state or pv marks them valid, and those do reset.
    if (load_a)      frame_a <= bus.fft_frame;
    else if (move_p) frame_a <= frame_p;
    if (store_p)     frame_p <= bus.fft_frame;
  end

  // Scan counter, running maximum, pending flag and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv      <= 1'b0;
      idx     <= '0;
      max_pow <= '0;
      max_idx <= '0;
      freq_q  <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      done_q <= last;
      drop_q <= drop;
      if (last) freq_q <= better ? idx : max_idx;
      if (store_p)       pv <= 1'b1;
      else if (clear_pv) pv <= 1'b0;
      if (start) begin
        idx     <= '0;
        max_pow <= '0;
        max_idx <= '0;
      end else if (state_q == SCAN) begin
        idx <= idx + 1'b1;
        if (better) begin
          max_pow <= pow;
          max_idx <= idx;
        end
      end
    end
  end

  // Output drive.
  always_comb begin
    bus.done       = done_q;
    bus.freq       = freq_q;
    bus.frame_drop = drop_q;
    bus.busy       = (state_q == SCAN) | pv;
  end

endmodule
